dst_data_seq: RTL and testbench

Sequencer for the blitter destination data latch bank (8 × LD2A, load enable `LDDSTL`). It arbitrates two writers of the latch: blitter destination-byte fetches from memory, and CPU writes to the destination data register. It also runs the memory request/acknowledge/ready handshake, with a wait timeout. It sits between the blitter control FSM, the memory controller and the existing destination data register, and drives that register's `ID_0..ID_7` and `LDDSTL` inputs.

---
 rtl/dst_data_seq_pkg.sv | 30 +++
 rtl/dst_data_seq_if.sv | 34 +++
 rtl/dst_data_seq_wait_timer.sv | 37 +++
 rtl/dst_data_seq.sv | 148 ++++++++++++++
 tb/tb_dst_data_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dst_data_seq_pkg.sv
// ---------------------------------------------------------------------------
// Package : slipstream_dst_pkg
// Shared state encoding and constants for the destination data sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package slipstream_dst_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLOAD = 3'd5
  } dst_seq_state_t;

  // Default wait budget, in cycles spent in WAIT before abandoning a fetch
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // Terminal count of the wait timer for a given budget (legal budget 1..255)
  function automatic logic [7:0] tc_value(input int unsigned tmo);
    return 8'(tmo - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dst_data_seq_if.sv
// ---------------------------------------------------------------------------
// Interface : dst_data_seq_if
// Handshake and data bus between the blitter/CPU/memory side (master) and
// the destination data sequencer (slave).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dst_data_seq_if;
  logic       DFETCH;
  logic       CPUWR;
  logic [7:0] CPUD;
  logic       MEMACK;
  logic       MEMRDY;
  logic [7:0] MEMD;
  logic       MEMREQ;
  logic       LDDSTL;
  logic [7:0] ID;
  logic       DREADY;
  logic       TOERR;
  logic       BUSY;

  modport master (
    output DFETCH, CPUWR, CPUD, MEMACK, MEMRDY, MEMD,
    input  MEMREQ, LDDSTL, ID, DREADY, TOERR, BUSY
  );

  modport slave (
    input  DFETCH, CPUWR, CPUD, MEMACK, MEMRDY, MEMD,
    output MEMREQ, LDDSTL, ID, DREADY, TOERR, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/dst_data_seq_wait_timer.sv
// ---------------------------------------------------------------------------
// Module  : dst_wait_timer
// 8-bit wait counter with synchronous clear/enable; tc flags TIMEOUT-1.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dst_wait_timer
  import slipstream_dst_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tc
);

  localparam logic [7:0] C_TC = tc_value(TIMEOUT);

  logic [7:0] r_count;

  // Count cycles spent waiting; clear wins over enable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= 8'd0;
    end else if (en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign tc = (r_count == C_TC);

endmodule

`default_nettype wire

// File: rtl/dst_data_seq.sv
// ---------------------------------------------------------------------------
// Module  : dst_data_seq
// Sequencer for the blitter destination data latch bank. Arbitrates memory
// fetches and CPU writes onto ID/LDDSTL and runs the memory handshake with a
// wait timeout. CPU writes arriving while busy are parked and replayed once
// the sequencer returns to IDLE, so the CPU value overrides fetched data.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dst_data_seq
  import slipstream_dst_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic      MasterClock,
  input  wire logic      RESET,
  dst_data_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_REQ   = ST_REQ;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] S_CLOAD = ST_CLOAD;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [7:0] r_id;
  logic [7:0] r_pend_data;
  logic       r_pend;
  logic       r_tmo;
  logic       w_tc;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic       w_mem_cap;
  logic       w_timeout;

  // Memory data is captured on a same-cycle grant+ready in REQ or ready in WAIT
  assign w_mem_cap = ((r_state == S_REQ)  && bus.MEMACK && bus.MEMRDY) ||
                     ((r_state == S_WAIT) && bus.MEMRDY);

  // Wait budget exhausted with no data arriving this cycle
  assign w_timeout = (r_state == S_WAIT) && !bus.MEMRDY && w_tc;

  // Hold the timer at zero while requesting so WAIT always starts from 0
  assign w_tmr_clr = (r_state == S_REQ);
  assign w_tmr_en  = (r_state == S_WAIT) && !bus.MEMRDY && !w_tc;

  dst_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk (MasterClock),
    .rst (RESET),
    .clr (w_tmr_clr),
    .en  (w_tmr_en),
    .tc  (w_tc)
  );

  // Next-state decode; CPU write outranks pending replay, which outranks fetch
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.CPUWR || r_pend) begin
          w_next = S_CLOAD;
        end else if (bus.DFETCH) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.MEMACK && bus.MEMRDY) begin
          w_next = S_LOAD;
        end else if (bus.MEMACK) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.MEMRDY) begin
          w_next = S_LOAD;
        end else if (w_tc) begin
          w_next = S_DONE;
        end
      end
      S_LOAD:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_CLOAD: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch-input data: changes only on IDLE->CLOAD and on memory capture
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_id <= 8'h00;
    end else if ((r_state == S_IDLE) && bus.CPUWR) begin
      r_id <= bus.CPUD;
    end else if ((r_state == S_IDLE) && r_pend) begin
      r_id <= r_pend_data;
    end else if (w_mem_cap) begin
      r_id <= bus.MEMD;
    end
  end

  // Pending CPU write; a fresh write in IDLE supersedes any parked value
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_pend      <= 1'b0;
      r_pend_data <= 8'h00;
    end else if ((r_state != S_IDLE) && bus.CPUWR) begin
      r_pend      <= 1'b1;
      r_pend_data <= bus.CPUD;
    end else if (r_state == S_IDLE) begin
      r_pend      <= 1'b0;
    end
  end

  // Timeout flag: set on abandoning WAIT, reported and cleared in DONE
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      r_tmo <= 1'b0;
    end else if (w_timeout) begin
      r_tmo <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_tmo <= 1'b0;
    end
  end

  assign bus.MEMREQ = (r_state == S_REQ);
  assign bus.LDDSTL = (r_state == S_LOAD) || (r_state == S_CLOAD);
  assign bus.ID     = r_id;
  assign bus.DREADY = (r_state == S_DONE);
  assign bus.TOERR  = (r_state == S_DONE) && r_tmo;
  assign bus.BUSY   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dst_data_seq.sv
// ---------------------------------------------------------------------------
// Module  : tb_dst_data_seq
// Scoreboard bench for dst_data_seq: stimulus tasks plan each transaction's
// timeline and push expected load/ready events; a negedge monitor pops them.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dst_data_seq;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dst_data_seq_if bus ();

  dst_data_seq #(
    .TIMEOUT (TMO)
  ) dut (
    .MasterClock (clk),
    .RESET       (rst),
    .bus         (bus)
  );

  // Cycle index: inputs driven while cyc==k are sampled in cycle k; outputs
  // seen while cyc==k belong to cycle k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_id = 8'h00;

  typedef struct {
    bit         is_ld;
    logic [7:0] val;
    bit         toerr;
    int         at;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every LDDSTL / DREADY presented must match the next expected event
  bit prev_ld = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (bus.LDDSTL === 1'b1) begin
      if (prev_ld) check("lddstl_back_to_back", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_lddstl", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_load", 1, 32'(e.is_ld));
        check("load_cycle", cyc, e.at);
        check("load_data", bus.ID, e.val);
      end
    end
    if (bus.DREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_ready", 0, 32'(e.is_ld));
        check("ready_cycle", cyc, e.at);
        check("toerr", bus.TOERR, 32'(e.toerr));
      end
    end
    if ((bus.TOERR === 1'b1) && (bus.DREADY !== 1'b1)) check("toerr_without_dready", 1, 0);
    prev_ld = (bus.LDDSTL === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit df, input bit wr, input logic [7:0] cd,
                       input bit ack, input bit rdy, input logic [7:0] md);
    bus.DFETCH = df;
    bus.CPUWR  = wr;
    bus.CPUD   = cd;
    bus.MEMACK = ack;
    bus.MEMRDY = rdy;
    bus.MEMD   = md;
  endtask

  task automatic drain_check;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check("final_id", bus.ID, last_id);
  endtask

  // CPU write while idle: load one cycle later, no memory request
  task automatic do_cpu(input logic [7:0] cd);
    int c0;
    c0 = cyc;
    exp_q.push_back('{1'b1, cd, 1'b0, c0 + 1});
    check("cpu_busy_idle", bus.BUSY, 0);
    drive(1'b0, 1'b1, cd, 1'b0, 1'b0, 8'($urandom));
    tick();
    check("cpu_busy_cload", bus.BUSY, 1);
    check("cpu_memreq", bus.MEMREQ, 0);
    drive(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 8'($urandom));
    tick();
    check("cpu_busy_after", bus.BUSY, 0);
    last_id = cd;
    drain_check();
  endtask

  // One fetch transaction. ack_dly: cycles in REQ before grant. same: grant
  // and ready together. wdly: WAIT cycles before ready (>= TMO times out).
  // wt0/wt1: offsets of CPU writes while busy (-1 = none).
  task automatic do_fetch(input bit with_cpu, input logic [7:0] cd, input int ack_dly,
                          input bit same, input int wdly, input logic [7:0] md,
                          input int wt0, input logic [7:0] wd0,
                          input int wt1, input logic [7:0] wd1);
    int c0, s, a, m, r, t0, t1, last;
    bit pend, busy_exp, wr;
    logic [7:0] pv, cdv;
    c0 = cyc;
    s  = with_cpu ? c0 + 2 : c0;
    a  = s + 1 + ack_dly;
    if (with_cpu) begin
      exp_q.push_back('{1'b1, cd, 1'b0, c0 + 1});
      last_id = cd;
    end
    if (same)            m = a;
    else if (wdly < TMO) m = a + 1 + wdly;
    else                 m = -1;
    if (m >= 0) begin
      exp_q.push_back('{1'b1, md, 1'b0, m + 1});
      r = m + 2;
      exp_q.push_back('{1'b0, 8'h00, 1'b0, r});
      last_id = md;
    end else begin
      r = a + TMO + 1;
      exp_q.push_back('{1'b0, 8'h00, 1'b1, r});
    end
    t0 = (wt0 < 0) ? -1 : s + 1 + (wt0 % (r - s));
    t1 = (wt1 < 0) ? -1 : s + 1 + (wt1 % (r - s));
    if (t0 == t1) t0 = -1;
    pend = 1'b0;
    pv   = 8'h00;
    if (t0 >= 0 || t1 >= 0) begin
      pend = 1'b1;
      pv   = (t1 > t0) ? wd1 : wd0;
      exp_q.push_back('{1'b1, pv, 1'b0, r + 2});
      last_id = pv;
    end
    last = pend ? r + 3 : r + 1;
    for (int t = c0; t <= last; t++) begin
      busy_exp = (with_cpu && t == c0 + 1) || (t >= s + 1 && t <= r) || (pend && t == r + 2);
      check("memreq", bus.MEMREQ, 32'(t >= s + 1 && t <= a));
      check("busy", bus.BUSY, 32'(busy_exp));
      wr  = (with_cpu && t == c0) || t == t0 || t == t1;
      cdv = (with_cpu && t == c0) ? cd : (t == t0) ? wd0 : (t == t1) ? wd1 : 8'($urandom);
      drive(t < r, wr, cdv,
            (t == a) || (t > a && t <= r && $urandom_range(0, 3) == 0),
            (t == m) || (m < 0 && t == r),
            (t == m) ? md : 8'($urandom));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drain_check();
  endtask

  // Reset while waiting with a parked CPU write: everything is discarded
  task automatic do_reset_abort;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    check("rst_seq_memreq_req", bus.MEMREQ, 1);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    check("rst_seq_busy_wait", bus.BUSY, 1);
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    check("rst_abort_memreq", bus.MEMREQ, 0);
    check("rst_abort_busy", bus.BUSY, 0);
    check("rst_abort_id", bus.ID, 8'h00);
    check("rst_abort_lddstl", bus.LDDSTL, 0);
    check("rst_abort_dready", bus.DREADY, 0);
    last_id = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_abort_idle_busy", bus.BUSY, 0);
    end
    drain_check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (3) tick();
    check("reset_memreq", bus.MEMREQ, 0);
    check("reset_lddstl", bus.LDDSTL, 0);
    check("reset_id", bus.ID, 8'h00);
    check("reset_dready", bus.DREADY, 0);
    check("reset_toerr", bus.TOERR, 0);
    check("reset_busy", bus.BUSY, 0);
    rst = 1'b0;
    tick();

    do_cpu(8'h3C);
    do_fetch(1'b0, 8'h00, 2, 1'b0, 1, 8'hA5, -1, 8'h00, -1, 8'h00);
    do_fetch(1'b1, 8'h11, 0, 1'b0, 0, 8'h22, -1, 8'h00, -1, 8'h00);
    do_fetch(1'b0, 8'h00, 1, 1'b0, 2, 8'h55, 2, 8'h77, 3, 8'h88);
    do_fetch(1'b0, 8'h00, 0, 1'b0, TMO, 8'hEE, -1, 8'h00, -1, 8'h00);
    do_fetch(1'b0, 8'h00, 1, 1'b0, TMO - 1, 8'h5A, -1, 8'h00, -1, 8'h00);
    do_fetch(1'b0, 8'h00, 0, 1'b1, 0, 8'h0F, -1, 8'h00, -1, 8'h00);
    do_reset_abort();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_cpu(8'($urandom));
      end else begin
        do_fetch($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3) == 0, $urandom_range(0, TMO + 1), 8'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1, 8'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
